boot_load_ctrl: RTL
===================

// Module: boot_load_ctrl
// PURPOSE
// - Boot sequencer between the UART receiver (rx_valid/rx_data) and program memory write port.
// - Holds the CPU in reset and frames the byte stream: sync byte, word count, N big-endian 32-bit words.
// - Writes words to consecutive word addresses, releases CPU reset, and reports timeout/length errors.
// PARAMETERS
// - DATA_WIDTH      32         instruction word width (fixed 4 bytes)
// - ADDR_WIDTH      8          program memory word-address width
// - MAX_WORDS       64         largest legal word count; must be <= 2**ADDR_WIDTH
// - TIMEOUT_CYCLES  1_000_000  max idle clk cycles between bytes inside a frame
// - SYNC_BYTE       8'hA5      frame start marker
// PORTS
// - clk         in   1           clock
// - arst_n      in   1           async active-low reset
// - rx_valid    in   1           one-cycle pulse, rx_data valid (UART rx_done)
// - rx_data     in   8           received byte
// - reload_req  in   1           one-cycle pulse: abort/restart load, CPU back into reset
// - mem_we      out  1           program memory write strobe, one cycle per word
// - mem_addr    out  ADDR_WIDTH  word address, 0..N-1
// - mem_wdata   out  DATA_WIDTH  word; first received byte in [31:24]
// - cpu_rst_n   out  1           CPU reset, active-low; high only in RUN
// - boot_done   out  1           level, program loaded and CPU released
// - boot_err    out  1           level, frame aborted
// - err_code    out  2           0 none, 1 bad length, 2 timeout, 3 checksum mismatch
// BEHAVIOUR
// - Reset (async): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, boot_done=0, boot_err=0, err_code=0; counters 0.
// - All outputs are flops. States: IDLE, GET_LEN, GET_BYTE, [GET_CSUM], RUN, ERROR.
// - IDLE: rx_valid with rx_data==SYNC_BYTE -> GET_LEN. Any other byte is dropped.
// - GET_LEN: byte N. If N==0 or N>MAX_WORDS -> ERROR, code 1. Otherwise latch N, word_idx=0, byte_idx=0 -> GET_BYTE.
// - GET_BYTE: byte_idx 0..3 fills [31:24],[23:16],[15:8],[7:0]. The 4th byte is accepted at cycle T:
//   - mem_we=1, mem_addr=word_idx, mem_wdata=word at T+1 only. No dedicated write state.
//   - A byte arriving at T+1 is accepted as byte 0 of the next word.
//   - word_idx==N-1 -> RUN (or GET_CSUM) at T+1; otherwise word_idx++ and byte_idx=0.
// - RUN: cpu_rst_n=1 and boot_done=1 from T+2, one cycle after the final mem_we. rx bytes are ignored.
// - Timeout: counter clears on every rx_valid and on entry to GET_LEN/GET_BYTE/GET_CSUM.
//   - It reaches TIMEOUT_CYCLES-1 in those states -> ERROR, code 2.
//   - It does not count in IDLE/RUN/ERROR.
// - ERROR: boot_err=1, cpu_rst_n=0, mem_we=0. Left only via reload_req.
// - reload_req (any state, highest priority over rx_valid in the same cycle):
//   - Next state IDLE; cpu_rst_n=0, boot_done=0, boot_err=0, err_code=0 next cycle.
//   - The partial word is discarded; no mem_we in the following cycle.
// - Memory contents already written are not cleared on error or reload.
// - mem_addr holds the last written address between strobes.
// CONFIGURATION
// - BOOT_CHECKSUM_EN defined:
//   - After the last word, FSM enters GET_CSUM and expects one byte = XOR of all 4N word bytes.
//   - Match -> RUN, with cpu_rst_n high 2 cycles after the byte.
//   - Mismatch -> ERROR, code 3. Words are already in memory, but the CPU stays in reset.
// - BOOT_CHECKSUM_EN undefined: no GET_CSUM state and no XOR accumulator; code 3 is never produced.
// STRUCTURE
// - boot_pkg: state enum boot_state_t, error enum boot_err_t (ERR_NONE/ERR_LEN/ERR_TIMEOUT/ERR_CSUM), default SYNC_BYTE.
// - Sub-module boot_timeout_cnt: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES).
// - The rest is one FSM plus a byte assembler in boot_load_ctrl.
// TESTING (TIMEOUT_CYCLES=200 in bench)
// - Frame A5,02,11,22,33,44,55,66,77,88:
//   - mem_we pulses: addr0=32'h11223344, then addr1=32'h55667788.
//   - cpu_rst_n=1 and boot_done=1 one cycle after the 2nd pulse.
// - Bytes 00,FF, then A5,00:
//   - Leading bytes are ignored.
//   - Length 0 -> boot_err=1, err_code=1, cpu_rst_n=0, no mem_we.
// - A5,01,DE,AD, then silence for 200 cycles -> err_code=2 and no mem_we.
//   - Then reload_req -> IDLE with all flags 0; A5,01,DE,AD,BE,EF -> addr0=32'hDEADBEEF.
// - In RUN: reload_req -> cpu_rst_n=0, boot_done=0 next cycle; a new frame reloads from addr 0.
// - Assert arst_n mid-word (after 2 bytes), then resend the full frame:
//   - The first mem_we carries only the new bytes.
//   - All outputs are at reset values during reset.
// - BOOT_CHECKSUM_EN: A5,01,01,02,04,08,0F -> RUN. The same frame with 0E -> err_code=3, cpu_rst_n=0.

Source files
------------

// File: rtl/boot_load_ctrl_pkg.sv
// Shared types and defaults for the boot loader.
// BOOT_CHECKSUM_EN adds the GET_CSUM state to the FSM encoding.
package boot_pkg;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_GET_LEN, ST_GET_BYTE, ST_GET_CSUM, ST_RUN, ST_ERROR
  } boot_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_GET_LEN, ST_GET_BYTE, ST_RUN, ST_ERROR
  } boot_state_t;
`endif

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_CSUM    = 2'd3
  } boot_err_t;

  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/boot_load_ctrl_if.sv
// UART byte stream in, program-memory write port out.
interface boot_load_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (output rx_valid, rx_data, input mem_we, mem_addr, mem_wdata);
  modport slave  (input rx_valid, rx_data, output mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/boot_load_ctrl_timeout_cnt.sv
// Idle-cycle counter between received bytes; expired once the count
// sits at TIMEOUT_CYCLES-1 while enabled.
module boot_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == LAST);
endmodule

// File: rtl/boot_load_ctrl.sv
// Boot sequencer: frames sync/length/words from the UART, writes program
// memory and releases CPU reset. Optional checksum byte: BOOT_CHECKSUM_EN.
module boot_load_ctrl
  import boot_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 8,
  parameter int         MAX_WORDS      = 64,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = BOOT_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               arst_n,
  boot_load_ctrl_if.slave    bus,
  input  logic               reload_req,
  output logic               cpu_rst_n,
  output logic               boot_done,
  output logic               boot_err,
  output logic [1:0]         err_code
);
  boot_state_t             state;
  boot_err_t               err_q;
  logic [7:0]              last_idx;
  logic [7:0]              word_idx;
  logic [1:0]              byte_idx;
  logic [DATA_WIDTH-9:0]   word_q;
  logic                    in_frame;
  logic                    tmo_expired;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  assign err_code = err_q;

`ifdef BOOT_CHECKSUM_EN
  assign in_frame = (state == ST_GET_LEN) || (state == ST_GET_BYTE) || (state == ST_GET_CSUM);
`else
  assign in_frame = (state == ST_GET_LEN) || (state == ST_GET_BYTE);
`endif

  // Every frame-state entry coincides with an accepted byte, so clearing
  // on rx_valid also covers the entry condition.
  boot_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .arst_n  (arst_n),
    .clear   (bus.rx_valid || !in_frame),
    .en      (in_frame),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= ST_IDLE;
      err_q         <= ERR_NONE;
      last_idx      <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      word_q        <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rst_n     <= 1'b0;
      boot_done     <= 1'b0;
      boot_err      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      if (reload_req) begin
        state     <= ST_IDLE;
        err_q     <= ERR_NONE;
        word_idx  <= '0;
        byte_idx  <= '0;
        cpu_rst_n <= 1'b0;
        boot_done <= 1'b0;
        boot_err  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_valid && bus.rx_data == SYNC_BYTE)
              state <= ST_GET_LEN;
          end
          ST_GET_LEN: begin
            if (bus.rx_valid) begin
              if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > MAX_WORDS) begin
                state    <= ST_ERROR;
                err_q    <= ERR_LEN;
                boot_err <= 1'b1;
              end else begin
                state    <= ST_GET_BYTE;
                last_idx <= bus.rx_data - 8'd1;
                word_idx <= '0;
                byte_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
                csum     <= '0;
`endif
              end
            end else if (tmo_expired) begin
              state    <= ST_ERROR;
              err_q    <= ERR_TIMEOUT;
              boot_err <= 1'b1;
            end
          end
          ST_GET_BYTE: begin
            if (bus.rx_valid) begin
              word_q <= {word_q[DATA_WIDTH-17:0], bus.rx_data};
`ifdef BOOT_CHECKSUM_EN
              csum   <= csum ^ bus.rx_data;
`endif
              if (byte_idx == 2'd3) begin
                // Write is issued straight from the byte-accept cycle.
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= ADDR_WIDTH'(word_idx);
                bus.mem_wdata <= {word_q, bus.rx_data};
                byte_idx      <= '0;
                if (word_idx == last_idx)
`ifdef BOOT_CHECKSUM_EN
                  state <= ST_GET_CSUM;
`else
                  state <= ST_RUN;
`endif
                else
                  word_idx <= word_idx + 8'd1;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end else if (tmo_expired) begin
              state    <= ST_ERROR;
              err_q    <= ERR_TIMEOUT;
              boot_err <= 1'b1;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          ST_GET_CSUM: begin
            if (bus.rx_valid) begin
              if (bus.rx_data == csum) begin
                state <= ST_RUN;
              end else begin
                state    <= ST_ERROR;
                err_q    <= ERR_CSUM;
                boot_err <= 1'b1;
              end
            end else if (tmo_expired) begin
              state    <= ST_ERROR;
              err_q    <= ERR_TIMEOUT;
              boot_err <= 1'b1;
            end
          end
`endif
          ST_RUN: begin
            cpu_rst_n <= 1'b1;
            boot_done <= 1'b1;
          end
          ST_ERROR: begin
            cpu_rst_n <= 1'b0;
            boot_err  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
